ahb2apb_bridge_mslv: RTL



---
 rtl/ahb2apb_bridge_mslv_pkg.sv | 25 ++
 rtl/ahb2apb_bridge_mslv_decode.sv | 21 ++
 rtl/ahb2apb_bridge_mslv.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ahb2apb_bridge_mslv_pkg.sv
// Shared encodings, FSM states and byte-strobe helper for the multi-slave AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_e;

  // Lane mask for a 2^hsize-byte beat, placed at the size-aligned byte offset.
  function automatic logic [7:0] size_to_strb(input logic [2:0] hsize,
                                               input logic [2:0] addr_lsbs,
                                               input int         dw);
    logic [2:0] align;
    align = addr_lsbs & 3'((dw / 8) - 1) & ~(3'((1 << hsize) - 1));
    return 8'(((9'd1 << (4'd1 << hsize)) - 9'd1) << align);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_mslv_decode.sv
// Address-phase decode: slave index, illegal slave/size detection and write strobes.
module ahb2apb_slv_decode import ahb2apb_pkg::*; #(
  parameter int DW   = 32,
  parameter int NSLV = 4,
  parameter int SW   = 2,
  parameter int BW   = 2,
  parameter int NB   = DW / 8
) (
  input  logic [SW-1:0] idx_field,
  input  logic [BW-1:0] addr_lsbs,
  input  logic [2:0]    hsize,
  output logic [SW-1:0] idx,
  output logic          dec_err,
  output logic [NB-1:0] strb
);

  assign idx     = idx_field;
  assign dec_err = (32'(idx_field) >= NSLV) || (hsize > 3'(BW));
  assign strb    = NB'(size_to_strb(hsize, 3'(addr_lsbs), DW));

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite slave to NSLV-way APB4 bridge with wait states, slave/decode errors and access timeout.
module ahb2apb_bridge_mslv import ahb2apb_pkg::*; #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               hsel,
  input  logic [AW-1:0]      haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [DW-1:0]      hwdata,
  input  logic               hready_in,
  output logic               hready_out,
  output logic               hresp,
  output logic [DW-1:0]      hrdata,
  output logic [AW-1:0]      paddr,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  output logic [DW/8-1:0]    pstrb,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int SW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int BW  = $clog2(DW / 8);
  localparam int NB  = DW / 8;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state, nxt;
  logic            accept, dec_err, sel_rdy, sel_err, tmo, write_q;
  logic [SW-1:0]   dec_idx, idx_q;
  logic [NB-1:0]   dec_strb, strb_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   pwdata_q, hrdata_q, rd_mux;
  logic [NSLV-1:0] sel_oh;
  logic [TCW-1:0]  tcnt;

  ahb2apb_slv_decode #(.DW(DW), .NSLV(NSLV), .SW(SW), .BW(BW), .NB(NB)) u_dec (
    .idx_field (haddr[SLV_LSB +: SW]),
    .addr_lsbs (haddr[BW-1:0]),
    .hsize     (hsize),
    .idx       (dec_idx),
    .dec_err   (dec_err),
    .strb      (dec_strb)
  );

  for (genvar i = 0; i < NSLV; i++) begin : g_sel
    assign sel_oh[i] = (idx_q == SW'(i));
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++)
      if (sel_oh[i]) rd_mux = rd_mux | prdata[i*DW +: DW];
  end

  assign sel_rdy = |(pready & sel_oh);
  assign sel_err = |(pslverr & sel_oh);
  assign tmo     = (TIMEOUT > 0) && (32'(tcnt) == TIMEOUT - 1);
  // A new address phase may only land while HREADYOUT is high.
  assign accept  = hsel && hready_in && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) &&
                   (state == ST_IDLE || state == ST_DONE || state == ST_ERR2);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2:
        nxt = !accept ? ST_IDLE : dec_err ? ST_ERR1 : hwrite ? ST_WDATA : ST_SETUP;
      ST_WDATA:  nxt = ST_SETUP;
      ST_SETUP:  nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_rdy)  nxt = sel_err ? ST_ERR1 : ST_DONE;
        else if (tmo) nxt = ST_ERR1;
      end
      ST_ERR1:   nxt = ST_ERR2;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      strb_q   <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      tcnt     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        idx_q   <= dec_idx;
        strb_q  <= dec_strb;
      end
      if (state == ST_WDATA) pwdata_q <= hwdata;
      if (state == ST_SETUP) tcnt <= '0;
      else if (state == ST_ACCESS && !sel_rdy && !tmo) tcnt <= tcnt + TCW'(1);
      // Errored or write completions leave the last read data in place.
      if (state == ST_ACCESS && sel_rdy && !sel_err && !write_q) hrdata_q <= rd_mux;
    end
  end

  assign hready_out = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
  assign hresp      = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata     = hrdata_q;
  assign paddr      = addr_q;
  assign psel       = (state == ST_SETUP || state == ST_ACCESS) ? sel_oh : '0;
  assign penable    = (state == ST_ACCESS);
  assign pwrite     = write_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = write_q ? strb_q : '0;

endmodule
